// File: rtl/chien_search_if.sv
// rtl/chien_search_if.sv - request/result bundle for the Chien-search root finder
// The master side drives the job inputs and start; the slave side is the search engine.
interface chien_search_if #(
  parameter int T_MAX = 4,
  parameter int M_MAX = 10
);
  logic                         start;
  logic [3:0]                   t;
  logic [3:0]                   m;
  logic                         failure;
  logic [3:0]                   degree;
  logic [(T_MAX+1)*M_MAX-1:0]   sigma;
  logic                         busy;
  logic                         err_valid;
  logic [M_MAX-1:0]             err_pos;
  logic                         done;
  logic                         uncorrectable;
  logic [3:0]                   err_cnt;

  modport master (
    output start, t, m, failure, degree, sigma,
    input  busy, err_valid, err_pos, done, uncorrectable, err_cnt
  );

  modport slave (
    input  start, t, m, failure, degree, sigma,
    output busy, err_valid, err_pos, done, uncorrectable, err_cnt
  );
endinterface

// File: rtl/chien_search.sv
// rtl/chien_search.sv - Chien-search root finder, one GF(2^m) element per cycle
// Evaluates sigma(alpha^i) for i=0..2^m-2 and streams the matching error positions.
module chien_search #(
  parameter int T_MAX = 4,
  parameter int M_MAX = 10
) (
  input  logic          clk,
  input  logic          rst,
  chien_search_if.slave cs
);
  localparam int TW = T_MAX + 1;
  localparam logic [M_MAX-1:0] POLY6  = M_MAX'(10'h003);
  localparam logic [M_MAX-1:0] POLY8  = M_MAX'(10'h01D);
  localparam logic [M_MAX-1:0] POLY10 = M_MAX'(10'h009);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       m_q, m_d;
  logic [3:0]       t_q, t_d;
  logic [3:0]       deg_q, deg_d;
  logic             imm_fail_q, imm_fail_d;
  logic [M_MAX-1:0] r_q [TW];
  logic [M_MAX-1:0] r_d [TW];
  logic [M_MAX-1:0] i_q, i_d;
  logic             busy_q, busy_d;
  logic             err_valid_q, err_valid_d;
  logic [M_MAX-1:0] err_pos_q, err_pos_d;
  logic             done_q, done_d;
  logic             unc_q, unc_d;
  logic [3:0]       cnt_q, cnt_d;

  logic [M_MAX-1:0] sum;
  logic [M_MAX-1:0] n_cur;
  logic [M_MAX-1:0] mask_in;
  logic [M_MAX-1:0] tmp;
  logic             m_ok;
  logic             imm;

  // Low m bits set; for a valid field this is also n = 2^m-1.
  function automatic logic [M_MAX-1:0] field_mask(input logic [3:0] mm);
    logic [M_MAX-1:0] mk;
    mk = '0;
    for (int b = 0; b < M_MAX; b++) begin
      mk[b] = (b < int'(mm));
    end
    return mk;
  endfunction

  function automatic logic [M_MAX-1:0] mul_alpha(input logic [M_MAX-1:0] x,
                                                 input logic [3:0]       mm);
    logic [M_MAX-1:0] y;
    logic [M_MAX-1:0] poly;
    case (mm)
      4'd6:    poly = POLY6;
      4'd8:    poly = POLY8;
      default: poly = POLY10;
    endcase
    y = {x[M_MAX-2:0], 1'b0} & field_mask(mm);
    if (x[mm - 4'd1]) begin
      y = y ^ poly;
    end
    return y;
  endfunction

  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    t_d         = t_q;
    deg_d       = deg_q;
    imm_fail_d  = imm_fail_q;
    i_d         = i_q;
    busy_d      = busy_q;
    err_valid_d = 1'b0;
    err_pos_d   = err_pos_q;
    done_d      = 1'b0;
    unc_d       = unc_q;
    cnt_d       = cnt_q;
    tmp         = '0;
    for (int j = 0; j < TW; j++) begin
      r_d[j] = r_q[j];
    end

    sum = '0;
    for (int j = 0; j < TW; j++) begin
      sum = sum ^ r_q[j];
    end
    n_cur   = field_mask(m_q);
    mask_in = field_mask(cs.m);
    m_ok    = (cs.m == 4'd6) || (cs.m == 4'd8) || (cs.m == 4'd10);
    imm     = cs.failure || !m_ok || ((cs.sigma[M_MAX-1:0] & mask_in) == '0);

    case (state_q)
      IDLE: begin
        if (cs.start) begin
          m_d        = cs.m;
          t_d        = cs.t;
          deg_d      = cs.degree;
          imm_fail_d = imm;
          for (int j = 0; j < TW; j++) begin
            r_d[j] = (j <= int'(cs.t)) ? (cs.sigma[j*M_MAX +: M_MAX] & mask_in) : '0;
          end
          cnt_d   = '0;
          unc_d   = 1'b0;
          busy_d  = 1'b1;
          i_d     = '0;
          state_d = imm ? DONE : SCAN;
        end
      end
      SCAN: begin
        // r_j holds sigma_j * alpha^(i*j), so the XOR of all terms is sigma(alpha^i).
        for (int j = 0; j < TW; j++) begin
          tmp = r_q[j];
          for (int k = 0; k < T_MAX; k++) begin
            if (k < j) begin
              tmp = mul_alpha(tmp, m_q);
            end
          end
          r_d[j] = tmp;
        end
        if (sum == '0) begin
          err_valid_d = 1'b1;
          err_pos_d   = (i_q == '0) ? '0 : (n_cur - i_q);
          cnt_d       = (cnt_q == 4'hF) ? cnt_q : (cnt_q + 4'd1);
        end
        i_d = i_q + 1'b1;
        if (i_q == (n_cur - 1'b1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        unc_d   = imm_fail_q || (cnt_q != deg_q) || (deg_q > t_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      m_q         <= '0;
      t_q         <= '0;
      deg_q       <= '0;
      imm_fail_q  <= 1'b0;
      i_q         <= '0;
      busy_q      <= 1'b0;
      err_valid_q <= 1'b0;
      err_pos_q   <= '0;
      done_q      <= 1'b0;
      unc_q       <= 1'b0;
      cnt_q       <= '0;
      for (int j = 0; j < TW; j++) begin
        r_q[j] <= '0;
      end
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      t_q         <= t_d;
      deg_q       <= deg_d;
      imm_fail_q  <= imm_fail_d;
      i_q         <= i_d;
      busy_q      <= busy_d;
      err_valid_q <= err_valid_d;
      err_pos_q   <= err_pos_d;
      done_q      <= done_d;
      unc_q       <= unc_d;
      cnt_q       <= cnt_d;
      for (int j = 0; j < TW; j++) begin
        r_q[j] <= r_d[j];
      end
    end
  end

  assign cs.busy          = busy_q;
  assign cs.err_valid     = err_valid_q;
  assign cs.err_pos       = err_pos_q;
  assign cs.done          = done_q;
  assign cs.uncorrectable = unc_q;
  assign cs.err_cnt       = cnt_q;
endmodule

// File: tb/tb_chien_search.sv
// tb/tb_chien_search.sv - scoreboard bench for chien_search
// A table-driven GF model predicts strobe edges, positions and verdicts for each job.
module tb_chien_search;
  localparam int T_MAX = 4;
  localparam int M_MAX = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  chien_search_if #(.T_MAX(T_MAX), .M_MAX(M_MAX)) cs();
  chien_search #(.T_MAX(T_MAX), .M_MAX(M_MAX)) dut (.clk(clk), .rst(rst), .cs(cs));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {int at; int pos;} ev_t;
  typedef struct {int at; int cnt; int unc;} dn_t;
  ev_t ev_q[$];
  dn_t dn_q[$];

  function automatic int fpoly(input int m);
    case (m)
      6:       return 'h43;
      8:       return 'h11D;
      default: return 'h409;
    endcase
  endfunction

  function automatic int gf_mul(input int a, input int b, input int m);
    int r, aa;
    r  = 0;
    aa = a;
    for (int k = 0; k < m; k++) begin
      if (b[k]) r ^= aa;
      aa = aa << 1;
      if (aa[m]) aa ^= fpoly(m);
    end
    return r;
  endfunction

  function automatic logic [49:0] pk(input int s0, input int s1, input int s2,
                                     input int s3, input int s4);
    return {s4[9:0], s3[9:0], s2[9:0], s1[9:0], s0[9:0]};
  endfunction

  task automatic model_job(input int e0, input int m, input int t, input int deg,
                           input bit fail, input logic [49:0] sig);
    int n, cnt, mask, acc;
    int s[5];
    int pw[1024];
    mask = (1 << m) - 1;
    for (int j = 0; j < 5; j++) s[j] = (j <= t) ? (int'(sig[j*10 +: 10]) & mask) : 0;
    if (fail || !(m == 6 || m == 8 || m == 10) || s[0] == 0) begin
      dn_q.push_back('{at: e0 + 1, cnt: 0, unc: 1});
      return;
    end
    n = mask;
    pw[0] = 1;
    for (int k = 1; k < n; k++) pw[k] = gf_mul(pw[k-1], 2, m);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      acc = 0;
      for (int j = 0; j < 5; j++) acc ^= gf_mul(s[j], pw[(i * j) % n], m);
      if (acc == 0) begin
        ev_q.push_back('{at: e0 + i + 1, pos: (i == 0) ? 0 : n - i});
        cnt++;
      end
    end
    dn_q.push_back('{at: e0 + n + 1, cnt: cnt, unc: ((cnt != deg) || (deg > t)) ? 1 : 0});
  endtask

  always @(negedge clk) begin
    ev_t e;
    dn_t d;
    if (!rst) begin
      if (cs.err_valid) begin
        if (ev_q.size() == 0) begin
          check("unexpected_err_valid", 1, 0);
        end else begin
          e = ev_q.pop_front();
          check("err_pos", 32'(cs.err_pos), e.pos);
          check("err_valid_edge", cyc, e.at);
          check("busy_while_scan", 32'(cs.busy), 1);
        end
      end
      if (cs.done) begin
        if (dn_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          d = dn_q.pop_front();
          check("done_edge", cyc, d.at);
          check("err_cnt", 32'(cs.err_cnt), d.cnt);
          check("uncorrectable", 32'(cs.uncorrectable), d.unc);
          check("busy_at_done", 32'(cs.busy), 0);
          check("missed_err_valid", ev_q.size(), 0);
          ev_q.delete();
        end
      end
    end
  end

  task automatic drive(input int m, input int t, input int deg, input bit fail,
                       input logic [49:0] sig, output int e0);
    @(negedge clk);
    cs.m       = 4'(m);
    cs.t       = 4'(t);
    cs.degree  = 4'(deg);
    cs.failure = fail;
    cs.sigma   = sig;
    cs.start   = 1'b1;
    e0 = cyc + 1;
    model_job(e0, m, t, deg, fail, sig);
    @(negedge clk);
    cs.start = 1'b0;
  endtask

  task automatic run_job(input int m, input int t, input int deg, input bit fail,
                         input logic [49:0] sig, input bit poke);
    int e0, budget;
    drive(m, t, deg, fail, sig, e0);
    if (poke) begin
      repeat (40) @(negedge clk);
      cs.start   = 1'b1;
      cs.failure = 1'b1;
      cs.m       = 4'd6;
      cs.sigma   = '0;
      @(negedge clk);
      cs.start = 1'b0;
    end
    budget = 0;
    while (dn_q.size() != 0 && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    check("job_timeout", dn_q.size(), 0);
    dn_q.delete();
  endtask

  initial begin
    int e0;
    int a, b;
    cs.start = 1'b0; cs.m = '0; cs.t = '0; cs.degree = '0; cs.failure = 1'b0; cs.sigma = '0;
    #1;
    check("rst_busy", 32'(cs.busy), 0);
    check("rst_err_valid", 32'(cs.err_valid), 0);
    check("rst_done", 32'(cs.done), 0);
    check("rst_err_cnt", 32'(cs.err_cnt), 0);
    check("rst_unc", 32'(cs.uncorrectable), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_job(8, 4, 1, 0, pk(1, 'h20, 0, 0, 0), 1);
    check("single_err_cnt", 32'(cs.err_cnt), 1);
    run_job(8, 4, 2, 0, pk(1, 'h09, 'h08, 0, 0), 0);
    run_job(8, 4, 3, 0, pk(1, 'h09, 'h08, 0, 0), 0);
    check("deg3_unc", 32'(cs.uncorrectable), 1);
    run_job(8, 4, 1, 1, pk(1, 'h20, 0, 0, 0), 0);
    run_job(7, 4, 1, 0, pk(1, 'h20, 0, 0, 0), 0);
    run_job(8, 4, 1, 0, pk(0, 'h20, 0, 0, 0), 0);
    run_job(6, 4, 1, 0, pk(1, 'h02, 0, 0, 0), 0);
    check("m6_err_cnt", 32'(cs.err_cnt), 1);
    run_job(8, 4, 0, 0, pk(1, 0, 0, 0, 0), 0);
    check("deg0_unc", 32'(cs.uncorrectable), 0);
    run_job(8, 1, 1, 0, pk(1, 'h20, 'h55, 'h3C, 'h81), 0);
    a = 2; b = 4;
    run_job(10, 4, 2, 0, pk(1, a ^ b, gf_mul(a, b, 10), 0, 0), 0);
    run_job(10, 4, 3, 0, pk($urandom_range(1, 1023), $urandom_range(0, 1023),
                            $urandom_range(0, 1023), $urandom_range(0, 1023), 0), 0);

    drive(8, 4, 2, 0, pk(1, 'h09, 'h08, 0, 0), e0);
    while (cyc < e0 + 99) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", 32'(cs.busy), 0);
    check("abort_err_valid", 32'(cs.err_valid), 0);
    check("abort_err_pos", 32'(cs.err_pos), 0);
    check("abort_done", 32'(cs.done), 0);
    check("abort_err_cnt", 32'(cs.err_cnt), 0);
    check("abort_unc", 32'(cs.uncorrectable), 0);
    ev_q.delete();
    dn_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    run_job(8, 4, 1, 0, pk(1, 'h20, 0, 0, 0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
